sap_program_loader: RTL and testbench

Program loader sitting directly upstream of the SAP-1 control logic and RAM. It accepts a program as a byte stream over a valid/ready handshake and writes it into the 16x8 program RAM. It holds the CPU (control logic, PC, registers) in reset while loading, then releases it to run. It replaces manual DIP-switch programming on the Altera board.

---
 rtl/sap_program_loader_if.sv | 24 ++
 rtl/sap_program_loader.sv | 147 ++++++++++++++
 tb/tb_sap_program_loader.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sap_program_loader_if.sv
// Byte-stream and RAM-write bus between the program source and the SAP-1 loader.
interface sap_program_loader_if #(
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned DATA_WIDTH = 8
);
    logic                  byte_valid;
    logic [DATA_WIDTH-1:0] byte_data;
    logic                  byte_ready;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;

    // Program source: drives the stream, observes ready and the RAM writes.
    modport master (
        output byte_valid, byte_data,
        input  byte_ready, mem_we, mem_addr, mem_wdata
    );

    // Loader: consumes the stream, drives the RAM write port.
    modport slave (
        input  byte_valid, byte_data,
        output byte_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/sap_program_loader.sv
// Streams a program into the SAP-1 16x8 RAM and holds the CPU in reset until loading is done.
module sap_program_loader #(
    parameter int unsigned ADDR_WIDTH  = 4,
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned HOLD_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  abort,
    input  logic [ADDR_WIDTH:0]   prog_len,
    sap_program_loader_if.slave   bus,
    output logic                  cpu_reset,
    output logic                  loading,
    output logic                  done
);
    localparam int unsigned CNT_W  = ADDR_WIDTH + 1;
    localparam int unsigned HOLD_W = 4;
    localparam logic [CNT_W-1:0]  DEPTH    = CNT_W'(1 << ADDR_WIDTH);
    localparam logic [HOLD_W-1:0] HOLD_END = HOLD_W'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_HOLD, S_RUN} state_e;

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [CNT_W-1:0]      len_q, len_d;
    logic [HOLD_W-1:0]     hold_q, hold_d;
    logic                  byte_ready_q, byte_ready_d;
    logic                  mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic                  cpu_reset_q, cpu_reset_d;
    logic                  loading_q, loading_d;
    logic                  done_q, done_d;

    logic                  accept_c;
    logic [CNT_W-1:0]      len_clamped_c;

    // A zero or oversized length means "fill the whole RAM".
    assign len_clamped_c = (prog_len == '0 || prog_len > DEPTH) ? DEPTH : prog_len;
    assign accept_c      = bus.byte_valid & byte_ready_q;

    // Next-state and next-output logic for the load sequence.
    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        len_d        = len_q;
        hold_d       = hold_q;
        byte_ready_d = byte_ready_q;
        mem_we_d     = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        cpu_reset_d  = cpu_reset_q;
        loading_d    = loading_q;
        done_d       = done_q;

        unique case (state_q)
            S_IDLE: begin
                cpu_reset_d = 1'b1;
                if (start) begin
                    len_d        = len_clamped_c;
                    count_d      = '0;
                    byte_ready_d = 1'b1;
                    loading_d    = 1'b1;
                    state_d      = S_LOAD;
                end
            end
            S_LOAD: begin
                // A byte accepted on the abort edge is still written.
                if (accept_c) begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = count_q[ADDR_WIDTH-1:0];
                    mem_wdata_d = bus.byte_data;
                    count_d     = count_q + CNT_W'(1);
                end
                if (abort) begin
                    byte_ready_d = 1'b0;
                    loading_d    = 1'b0;
                    state_d      = S_IDLE;
                end else if (accept_c && (count_q + CNT_W'(1)) == len_q) begin
                    byte_ready_d = 1'b0;
                    hold_d       = '0;
                    state_d      = S_HOLD;
                end
            end
            S_HOLD: begin
                cpu_reset_d = 1'b1;
                hold_d      = hold_q + HOLD_W'(1);
                if (hold_q == HOLD_END) begin
                    cpu_reset_d = 1'b0;
                    done_d      = 1'b1;
                    loading_d   = 1'b0;
                    state_d     = S_RUN;
                end
            end
            S_RUN: begin
                // Reload without a system reset: re-enter reset on the same edge.
                if (start) begin
                    len_d        = len_clamped_c;
                    count_d      = '0;
                    byte_ready_d = 1'b1;
                    loading_d    = 1'b1;
                    cpu_reset_d  = 1'b1;
                    done_d       = 1'b0;
                    state_d      = S_LOAD;
                end
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            count_q      <= '0;
            len_q        <= '0;
            hold_q       <= '0;
            byte_ready_q <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            cpu_reset_q  <= 1'b1;
            loading_q    <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            len_q        <= len_d;
            hold_q       <= hold_d;
            byte_ready_q <= byte_ready_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            cpu_reset_q  <= cpu_reset_d;
            loading_q    <= loading_d;
            done_q       <= done_d;
        end
    end

    assign bus.byte_ready = byte_ready_q;
    assign bus.mem_we     = mem_we_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;
    assign cpu_reset      = cpu_reset_q;
    assign loading        = loading_q;
    assign done           = done_q;
endmodule

// File: tb/tb_sap_program_loader.sv
// Bench for sap_program_loader: per-cycle check against a behavioural model plus directed literal checks.
module tb_sap_program_loader;
    localparam int HOLD = 4;

    logic       clk;
    logic       reset;
    logic       start;
    logic       abort;
    logic [4:0] prog_len;
    logic       cpu_reset;
    logic       loading;
    logic       done;

    sap_program_loader_if #(.ADDR_WIDTH(4), .DATA_WIDTH(8)) sif ();

    sap_program_loader #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .HOLD_CYCLES(HOLD)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .abort     (abort),
        .prog_len  (prog_len),
        .bus       (sif.slave),
        .cpu_reset (cpu_reset),
        .loading   (loading),
        .done      (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural model ----------------
    localparam int M_IDLE = 0, M_LOAD = 1, M_HOLD = 2, M_RUN = 3;
    int         m_mode, m_cnt, m_len, m_hold;
    bit         model_live = 0;
    logic       e_ready, e_we, e_cpu, e_load, e_done;
    logic [3:0] e_addr;
    logic [7:0] e_wdata;
    logic [7:0] m_ram [16];
    logic [7:0] d_ram [16];

    function automatic int clamp_len(input int p);
        return (p == 0 || p > 16) ? 16 : p;
    endfunction

    task automatic model_begin_load();
        m_len   = clamp_len(int'(prog_len));
        m_cnt   = 0;
        m_mode  = M_LOAD;
        e_ready = 1'b1;
        e_load  = 1'b1;
        e_cpu   = 1'b1;
        e_done  = 1'b0;
    endtask

    task automatic model_step();
        bit acc;
        if (reset) begin
            m_mode = M_IDLE; m_cnt = 0; m_len = 0; m_hold = 0;
            e_ready = 0; e_we = 0; e_addr = 0; e_wdata = 0;
            e_cpu = 1; e_load = 0; e_done = 0;
            return;
        end
        acc  = sif.byte_valid && e_ready;
        e_we = 1'b0;
        case (m_mode)
            M_IDLE: if (start) model_begin_load();
            M_LOAD: begin
                if (acc) begin
                    e_we    = 1'b1;
                    e_addr  = 4'(m_cnt);
                    e_wdata = sif.byte_data;
                    m_ram[m_cnt] = sif.byte_data;
                    m_cnt++;
                end
                if (abort) begin
                    m_mode = M_IDLE; e_ready = 0; e_load = 0;
                end else if (m_cnt == m_len) begin
                    m_mode = M_HOLD; e_ready = 0; m_hold = 0;
                end
            end
            M_HOLD: begin
                m_hold++;
                if (m_hold == HOLD) begin
                    m_mode = M_RUN; e_cpu = 0; e_done = 1; e_load = 0;
                end
            end
            default: if (start) model_begin_load();
        endcase
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
        model_live = 1;
    end

    // ---------------- compare process + write log ----------------
    typedef struct { int addr; int data; int cyc; } wr_t;
    wr_t  wlog[$];
    int   rel_cyc = -1;
    logic prev_cpu = 1'b1;

    initial forever begin
        @(negedge clk);
        cyc++;
        if (model_live) begin
            chk("byte_ready", 32'(sif.byte_ready), 32'(e_ready));
            chk("mem_we",     32'(sif.mem_we),     32'(e_we));
            chk("mem_addr",   32'(sif.mem_addr),   32'(e_addr));
            chk("mem_wdata",  32'(sif.mem_wdata),  32'(e_wdata));
            chk("cpu_reset",  32'(cpu_reset),      32'(e_cpu));
            chk("loading",    32'(loading),        32'(e_load));
            chk("done",       32'(done),           32'(e_done));
            if (sif.mem_we === 1'b1) begin
                wlog.push_back('{int'(sif.mem_addr), int'(sif.mem_wdata), cyc});
                d_ram[sif.mem_addr] = sif.mem_wdata;
            end
            if (prev_cpu === 1'b1 && cpu_reset === 1'b0) rel_cyc = cyc;
            prev_cpu = cpu_reset;
        end
    end

    // ---------------- stimulus helpers ----------------
    logic [7:0] tx[$];

    function automatic int log_field(input int i, input int f);
        if (i >= wlog.size()) return -1;
        return (f == 0) ? wlog[i].addr : (f == 1) ? wlog[i].data : wlog[i].cyc;
    endfunction

    task automatic pulse_start(input int len);
        start = 1'b1;
        prog_len = 5'(len);
        @(negedge clk);
        start = 1'b0;
    endtask

    // mode 0: valid held high, 1: valid every other cycle, 2: random valid
    task automatic send_bytes(input int mode, input int max_cyc);
        int i = 0;
        int c = 0;
        bit v, rdy;
        while (i < tx.size() && c < max_cyc) begin
            v = (mode == 0) ? 1'b1 : (mode == 1) ? (c % 2 == 0) : 1'($urandom_range(0, 1));
            sif.byte_valid = v;
            sif.byte_data  = v ? tx[i] : 8'($urandom);
            rdy = sif.byte_ready;
            @(negedge clk);
            if (v && rdy) i++;
            c++;
        end
        sif.byte_valid = 1'b0;
        chk("send_complete", 32'(i), 32'(tx.size()));
    endtask

    task automatic wait_done(input int max_cyc);
        int c = 0;
        while (done !== 1'b1 && c < max_cyc) begin
            @(negedge clk);
            c++;
        end
        chk("wait_done", 32'(done), 32'd1);
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        for (int i = 0; i < 16; i++) begin
            m_ram[i] = 8'h00;
            d_ram[i] = 8'h00;
        end
        reset = 1'b1; start = 1'b0; abort = 1'b0; prog_len = '0;
        sif.byte_valid = 1'b0; sif.byte_data = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        chk("idle_cpu_reset", 32'(cpu_reset), 32'd1);
        chk("idle_byte_ready", 32'(sif.byte_ready), 32'd0);
        chk("idle_mem_we", 32'(sif.mem_we), 32'd0);
        chk("idle_done", 32'(done), 32'd0);

        // three bytes, valid held high
        wlog.delete();
        tx = '{8'h1E, 8'h2F, 8'hE0};
        pulse_start(3);
        send_bytes(0, 20);
        wait_done(20);
        chk("s1_writes", 32'(wlog.size()), 32'd3);
        chk("s1_a0", 32'(log_field(0, 0)), 32'd0);
        chk("s1_d0", 32'(log_field(0, 1)), 32'h1E);
        chk("s1_a1", 32'(log_field(1, 0)), 32'd1);
        chk("s1_d1", 32'(log_field(1, 1)), 32'h2F);
        chk("s1_a2", 32'(log_field(2, 0)), 32'd2);
        chk("s1_d2", 32'(log_field(2, 1)), 32'hE0);
        chk("s1_back_to_back", 32'(log_field(2, 2) - log_field(0, 2)), 32'd2);
        chk("s1_hold_len", 32'(rel_cyc - log_field(2, 2)), 32'd4);

        // full RAM with prog_len=0, valid toggling, then extra valid with no 17th write
        wlog.delete();
        tx.delete();
        for (int i = 0; i < 16; i++) tx.push_back(8'(i));
        pulse_start(0);
        send_bytes(1, 200);
        sif.byte_valid = 1'b1;
        sif.byte_data  = 8'h77;
        repeat (10) @(negedge clk);
        sif.byte_valid = 1'b0;
        chk("s2_writes", 32'(wlog.size()), 32'd16);
        for (int i = 0; i < 16; i++) begin
            chk("s2_addr", 32'(log_field(i, 0)), 32'(i));
            chk("s2_data", 32'(log_field(i, 1)), 32'(i));
        end
        wait_done(20);

        // abort after 2 of 5 bytes, then a fresh 1-byte load
        wlog.delete();
        tx = '{8'h11, 8'h22};
        pulse_start(5);
        send_bytes(0, 20);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        repeat (3) @(negedge clk);
        chk("s3_writes", 32'(wlog.size()), 32'd2);
        chk("s3_a1", 32'(log_field(1, 0)), 32'd1);
        chk("s3_cpu_reset", 32'(cpu_reset), 32'd1);
        chk("s3_byte_ready", 32'(sif.byte_ready), 32'd0);
        chk("s3_done", 32'(done), 32'd0);
        wlog.delete();
        tx = '{8'hAA};
        pulse_start(1);
        send_bytes(0, 20);
        wait_done(20);
        chk("s3b_writes", 32'(wlog.size()), 32'd1);
        chk("s3b_a0", 32'(log_field(0, 0)), 32'd0);
        chk("s3b_d0", 32'(log_field(0, 1)), 32'hAA);

        // reload from RUN
        wlog.delete();
        start = 1'b1;
        prog_len = 5'd2;
        @(negedge clk);
        start = 1'b0;
        chk("s4_cpu_reset", 32'(cpu_reset), 32'd1);
        chk("s4_done", 32'(done), 32'd0);
        tx = '{8'h55, 8'h66};
        send_bytes(0, 20);
        wait_done(20);
        chk("s4_writes", 32'(wlog.size()), 32'd2);
        chk("s4_d0", 32'(log_field(0, 1)), 32'h55);
        chk("s4_d1", 32'(log_field(1, 1)), 32'h66);
        chk("s4_a1", 32'(log_field(1, 0)), 32'd1);

        // reset on the edge that would accept the next byte
        tx = '{8'h31};
        pulse_start(4);
        send_bytes(0, 20);
        sif.byte_valid = 1'b1;
        sif.byte_data  = 8'h99;
        reset = 1'b1;
        @(negedge clk);
        sif.byte_valid = 1'b0;
        chk("s5_mem_we", 32'(sif.mem_we), 32'd0);
        chk("s5_cpu_reset", 32'(cpu_reset), 32'd1);
        chk("s5_loading", 32'(loading), 32'd0);
        chk("s5_mem_addr", 32'(sif.mem_addr), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        wlog.delete();
        tx = '{8'hC3, 8'h3C};
        pulse_start(2);
        send_bytes(2, 50);
        wait_done(20);
        chk("s5b_writes", 32'(wlog.size()), 32'd2);
        chk("s5b_d1", 32'(log_field(1, 1)), 32'h3C);

        // randomized traffic, checked cycle-by-cycle by the model
        for (int c = 0; c < 3000; c++) begin
            start          = ($urandom_range(0, 99) < 5);
            abort          = ($urandom_range(0, 99) < 3);
            reset          = ($urandom_range(0, 199) == 0);
            prog_len       = 5'($urandom_range(0, 31));
            sif.byte_valid = ($urandom_range(0, 99) < 60);
            sif.byte_data  = 8'($urandom);
            @(negedge clk);
        end
        start = 1'b0; abort = 1'b0; reset = 1'b0; sif.byte_valid = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 16; i++) chk("ram_image", 32'(d_ram[i]), 32'(m_ram[i]));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
